// File: rtl/uw_frame_insert.sv
// LRPT transmit framer: prefixes every BITS_PER_FRAME-bit frame with the sync word, bursts of NUM_FRAMES.
// Optional leading zero-bit pad before the first sync word: define UW_FRAME_INSERT_PAD_EN.
module uw_frame_insert #(
  parameter int unsigned        BITS_PER_FRAME = 80,
  parameter int unsigned        UW_BITS        = 8,
  parameter int unsigned        NUM_FRAMES     = 32,
  parameter logic [UW_BITS-1:0] SYNC_WORD      = 8'h27
) (
  input  logic clk,
  input  logic rst_in_n,
  input  logic start,
`ifdef UW_FRAME_INSERT_PAD_EN
  input  logic [$clog2(BITS_PER_FRAME)-1:0] start_pad,
`endif
  input  logic data_in,
  input  logic valid_in,
  output logic ready_out,
  output logic hard_out,
  output logic valid_out,
  input  logic ready_in,
  output logic frame_start,
  output logic busy,
  output logic burst_done
);

  localparam int unsigned BW  = $clog2(BITS_PER_FRAME);
  localparam int unsigned FW  = $clog2(NUM_FRAMES) + 1;
  localparam int unsigned UIW = (UW_BITS > 1) ? $clog2(UW_BITS) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
`ifdef UW_FRAME_INSERT_PAD_EN
  localparam logic [2:0] S_PAD     = 3'd1;
`endif
  localparam logic [2:0] S_UW      = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]    state, state_n;
  logic [BW-1:0] bit_ctr, bit_ctr_n;
  logic [FW-1:0] frame_ctr, frame_ctr_n;
  logic          hard_out_n, valid_out_n, frame_start_n, busy_n, burst_done_n;
  logic          can_load;
  logic [UIW-1:0] uw_idx;
`ifdef UW_FRAME_INSERT_PAD_EN
  logic [BW-1:0] pad_ctr, pad_ctr_n;
`endif

  // Output register may take a new beat when empty or being drained this cycle.
  assign can_load = !valid_out || ready_in;
  assign uw_idx   = UIW'(UW_BITS - 1) - UIW'(bit_ctr);

  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state       <= S_IDLE;
      bit_ctr     <= '0;
      frame_ctr   <= '0;
      hard_out    <= 1'b0;
      valid_out   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      burst_done  <= 1'b0;
`ifdef UW_FRAME_INSERT_PAD_EN
      pad_ctr     <= '0;
`endif
    end else begin
      state       <= state_n;
      bit_ctr     <= bit_ctr_n;
      frame_ctr   <= frame_ctr_n;
      hard_out    <= hard_out_n;
      valid_out   <= valid_out_n;
      frame_start <= frame_start_n;
      busy        <= busy_n;
      burst_done  <= burst_done_n;
`ifdef UW_FRAME_INSERT_PAD_EN
      pad_ctr     <= pad_ctr_n;
`endif
    end
  end

  always_comb begin
    state_n       = state;
    bit_ctr_n     = bit_ctr;
    frame_ctr_n   = frame_ctr;
    hard_out_n    = hard_out;
    valid_out_n   = valid_out;
    frame_start_n = frame_start;
    busy_n        = busy;
    burst_done_n  = 1'b0;
    ready_out     = 1'b0;
`ifdef UW_FRAME_INSERT_PAD_EN
    pad_ctr_n     = pad_ctr;
`endif
    // Drained register empties unless a state below loads a new beat.
    if (can_load) begin
      valid_out_n   = 1'b0;
      frame_start_n = 1'b0;
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          busy_n      = 1'b1;
          bit_ctr_n   = '0;
          frame_ctr_n = '0;
`ifdef UW_FRAME_INSERT_PAD_EN
          pad_ctr_n   = start_pad;
          state_n     = (start_pad != '0) ? S_PAD : S_UW;
`else
          state_n     = S_UW;
`endif
        end
      end
`ifdef UW_FRAME_INSERT_PAD_EN
      S_PAD: begin
        if (can_load) begin
          hard_out_n  = 1'b0;
          valid_out_n = 1'b1;
          pad_ctr_n   = pad_ctr - BW'(1);
          if (pad_ctr == BW'(1)) state_n = S_UW;
        end
      end
`endif
      S_UW: begin
        if (can_load) begin
          hard_out_n    = SYNC_WORD[uw_idx];
          valid_out_n   = 1'b1;
          frame_start_n = (bit_ctr == '0);
          bit_ctr_n     = bit_ctr + BW'(1);
          if (bit_ctr == BW'(UW_BITS - 1)) state_n = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        ready_out = can_load;
        if (can_load && valid_in) begin
          hard_out_n  = data_in;
          valid_out_n = 1'b1;
          if (bit_ctr == BW'(BITS_PER_FRAME - 1)) begin
            bit_ctr_n   = '0;
            frame_ctr_n = frame_ctr + FW'(1);
            state_n     = (frame_ctr == FW'(NUM_FRAMES - 1)) ? S_DONE : S_UW;
          end else begin
            bit_ctr_n = bit_ctr + BW'(1);
          end
        end
      end
      S_DONE: begin
        if (can_load) begin
          burst_done_n = 1'b1;
          busy_n       = 1'b0;
          state_n      = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uw_frame_insert.sv
// Scoreboard bench for uw_frame_insert: expected beats queued per burst, monitor pops on each accepted beat.
module tb_uw_frame_insert;
  localparam int unsigned NF   = 2;
  localparam int unsigned BPF  = 80;
  localparam int unsigned UWB  = 8;
  localparam int unsigned PAYB = BPF - UWB;

  logic clk = 1'b0;
  logic rst_in_n = 1'b1;
  logic start = 1'b0, data_in = 1'b0, valid_in = 1'b0, ready_in = 1'b0;
  logic ready_out, hard_out, valid_out, frame_start, busy, burst_done;
`ifdef UW_FRAME_INSERT_PAD_EN
  logic [6:0] start_pad = 7'd0;
`endif

  always #5 clk = ~clk;

  uw_frame_insert #(
    .BITS_PER_FRAME(BPF), .UW_BITS(UWB), .NUM_FRAMES(NF), .SYNC_WORD(8'h27)
  ) dut (
    .clk(clk), .rst_in_n(rst_in_n), .start(start),
`ifdef UW_FRAME_INSERT_PAD_EN
    .start_pad(start_pad),
`endif
    .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
    .hard_out(hard_out), .valid_out(valid_out), .ready_in(ready_in),
    .frame_start(frame_start), .busy(busy), .burst_done(burst_done)
  );

  int cmp_cnt = 0, err_cnt = 0;
  logic [1:0] exp_q[$];   // {frame_start, bit}
  int pmode = 0, pidx = 0, gap_at = -1, gap_left = 0, rnd_ready = 0;
  bit start_req = 0, hs_in = 0;
  int cyc = 0, beats = 0, last_beat_cyc = 0, done_cyc = 0, done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic pat(input int k);
    case (pmode)
      1:       return logic'(k % 2);
      2:       return logic'((k % 3) == 0);
      default: return 1'b1;
    endcase
  endfunction

  task automatic push_burst();
    logic [7:0] sw;
    sw = 8'h27;
    for (int f = 0; f < int'(NF); f++) begin
      for (int b = 0; b < int'(UWB); b++) exp_q.push_back({logic'(b == 0), sw[7-b]});
      for (int b = 0; b < int'(PAYB); b++) exp_q.push_back({1'b0, pat(f * int'(PAYB) + b)});
    end
  endtask

  // Monitor: accepted beats against the scoreboard, plus hold-while-stalled checks.
  initial begin : monitor
    logic       stall;
    logic [2:0] held;
    logic [1:0] e;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_in_n) stall = 1'b0;
      if (stall) check("stall_hold", {29'd0, valid_out, frame_start, hard_out}, {29'd0, held});
      stall = valid_out && !ready_in && rst_in_n;
      held  = {valid_out, frame_start, hard_out};
      if (valid_out && ready_in) begin
        check("beat_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("beat_bit", hard_out, e[0]);
          check("beat_frame_start", frame_start, e[1]);
        end
        beats++;
        last_beat_cyc = cyc;
      end
      if (burst_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      hs_in = valid_in && ready_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (hs_in) pidx++;
    data_in   = pat(pidx);
    ready_in  = (rnd_ready != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    if (gap_at >= 0 && pidx == gap_at && gap_left > 0) begin
      valid_in = 1'b0;
      gap_left--;
    end else begin
      valid_in = 1'b1;
    end
    start     = start_req;
    start_req = 1'b0;
  endtask

  task automatic run_burst(input int rnd, input int gap, input bit mid_start, input int rst_at);
    int  beats0, done0;
    bit  aborted;
    rnd_ready = rnd;
    gap_at    = gap;
    gap_left  = 5;
    pidx      = 0;
    aborted   = 0;
    push_burst();
    beats0    = beats;
    done0     = done_cnt;
    start_req = 1'b1;
    for (int i = 0; i < 3000 && done_cnt == done0 && !aborted; i++) begin
      tick();
      if (i == 1) check("busy_after_start", busy, 1);
      if (mid_start && i == 50) start_req = 1'b1;
      if (rst_at >= 0 && (beats - beats0) >= rst_at) begin
        #2 rst_in_n = 1'b0;
        #1;
        check("rst_valid_out", valid_out, 0);
        check("rst_busy", busy, 0);
        check("rst_ready_out", ready_out, 0);
        exp_q.delete();
        tick();
        tick();
        rst_in_n = 1'b1;
        aborted  = 1;
      end
    end
    if (aborted) begin
      check("no_done_on_reset", done_cnt - done0, 0);
      tick();
      check("idle_after_reset", {busy, valid_out}, 0);
      return;
    end
    check("burst_done_seen", done_cnt - done0, 1);
    check("beat_count", beats - beats0, NF * BPF);
    check("queue_drained", exp_q.size(), 0);
    check("done_latency", done_cyc - last_beat_cyc, 1);
    exp_q.delete();
    tick();
    check("done_one_cycle", burst_done, 0);
    check("busy_after_done", busy, 0);
  endtask

  initial begin : stim
    #2 rst_in_n = 1'b0;
    repeat (3) tick();
    check("rst_hard_out", hard_out, 0);
    check("rst_valid_out", valid_out, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_busy", busy, 0);
    check("rst_burst_done", burst_done, 0);
    check("rst_ready_out", ready_out, 0);
    rst_in_n = 1'b1;
    repeat (2) tick();

    pmode = 0; run_burst(0, -1, 0, -1);   // all-ones payload, no backpressure
    repeat (3) tick();
    pmode = 0; run_burst(1, -1, 0, -1);   // random ready_in stalls
    repeat (3) tick();
    pmode = 1; run_burst(0, 30, 0, -1);   // 5-cycle valid_in gap mid-payload
    repeat (3) tick();
    pmode = 2; run_burst(1, -1, 1, -1);   // start pulsed during burst
    repeat (3) tick();
    pmode = 1; run_burst(0, -1, 0, 100);  // reset at beat 100
    repeat (3) tick();
    pmode = 2; run_burst(0, -1, 0, -1);   // restart after reset begins with the UW
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
